pipe_seg_adder: RTL
===================

PIPE_SEG_ADDER -- requirements
Module: pipe_seg_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand width in bits.
REQ-002 SHALL have parameter SEGS, default 2, meaning the number of carry-chain segments and pipeline stages; segment width SEG_W = WIDTH/SEGS.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning the operands on this cycle are to be accepted.
REQ-006 SHALL have port n1, input, WIDTH, meaning the first operand.
REQ-007 SHALL have port n2, input, WIDTH, meaning the second operand.
REQ-008 SHALL have port sub, input, 1, meaning compute n1-n2 when set (1) and n1+n2 when clear (0); sampled with the operands.
REQ-009 SHALL have port sgn, input, 1, meaning operands are two's-complement when set (1) and unsigned when clear (0); sampled with the operands.
REQ-010 SHALL have port hold, input, 1, meaning a pipeline stall: when set, every register keeps its value.
REQ-011 SHALL have port out_valid, output, 1, meaning sum and ovf carry a completed result.
REQ-012 SHALL have port sum, output, WIDTH+1, meaning the exact result in two's-complement WIDTH+1 bits.
REQ-013 SHALL have port ovf, output, 1, meaning the result does not fit in WIDTH bits of the selected mode.

Function
REQ-014 SHALL reject WIDTH not divisible by SEGS, or SEGS<1, at elaboration.
REQ-015 SHALL, for subtract, add the bitwise inverse of n2 with a carry-in of 1 into segment 0; for add, carry-in is 0.
REQ-016 SHALL add segment k (bits k*SEG_W..k*SEG_W+SEG_W-1) in pipeline stage k, using the registered carry-out of stage k-1.
REQ-017 SHALL delay the not-yet-added upper operand segments, and the already-computed lower sum segments, by skew registers so that all segments of one transaction leave together.
REQ-018 SHALL have a latency of exactly SEGS non-held cycles from in_valid=1 to out_valid=1; with SEGS=1 the latency is 1 cycle.
REQ-019 SHALL sustain throughput of one transaction per non-held cycle; back-to-back in_valid produces back-to-back out_valid in order.
REQ-020 SHALL carry a valid bit per stage; bubbles (in_valid=0) propagate as out_valid=0; sum and ovf are don't-care while out_valid=0.
REQ-021 SHALL form sum[WIDTH] as follows: in signed mode, sign extension of the exact result; in unsigned add, the carry-out; in unsigned subtract, the inverted carry-out (so that a negative result reads as two's complement).
REQ-022 SHALL set ovf as follows: in signed mode, when sum[WIDTH] != sum[WIDTH-1]; in unsigned mode, when sum[WIDTH]=1.
REQ-023 SHALL ignore in_valid, n1, n2, sub and sgn while hold=1; out_valid, sum and ovf stay unchanged during hold.
REQ-024 SHALL let rst take priority over hold and in_valid on the same edge.

Reset
REQ-025 SHALL, on rst=1 at a rising edge, clear all stage valid bits, out_valid, sum, ovf and all carry/skew registers to 0.
REQ-026 SHALL discard all in-flight transactions on reset mid-operation; the first result after reset appears SEGS cycles after the first post-reset in_valid.

Structure
REQ-027 SHALL place no typedefs in a shared package; SEG_W is a local constant derived from the parameters.
REQ-028 SHALL use one sub-module, adder_seg: a SEG_W-bit add with carry-in, sum-out and carry-out, combinational; pipe_seg_adder owns all registers.

Verification (WIDTH=16, SEGS=2, latency 2)
REQ-029 SHALL cover signed add 0x7FFF+0x0001 -> sum=17'h08000, ovf=1; signed add 0xFFFF+0xFFFF -> sum=17'h1FFFE, ovf=0.
REQ-030 SHALL cover unsigned add 0xFFFF+0x0001 -> sum=17'h10000, ovf=1; cross-segment carry 0x00FF+0x0001 -> sum=17'h00100, ovf=0.
REQ-031 SHALL cover unsigned sub 0x0000-0x0001 -> sum=17'h1FFFF, ovf=1; signed sub 0x8000-0x0001 -> sum=17'h17FFF, ovf=1.
REQ-032 SHALL cover four back-to-back transactions with one in_valid=0 gap -> results in order at cycle+2, with one out_valid=0 gap.
REQ-033 SHALL cover hold=1 for 3 cycles with two transactions in flight -> outputs frozen during hold; results emerge 2 non-held cycles after issue.
REQ-034 SHALL cover rst pulsed one cycle after issuing a transaction -> out_valid never asserts for it; outputs read 0 next cycle.

Source files
------------

// File: rtl/adder_seg.sv
// One carry-chain segment: W-bit add with carry-in and carry-out, purely combinational.
// Zero latency; no flow control, so the caller owns registering and stalling.
module adder_seg #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/pipe_seg_adder.sv
// Segmented pipelined add/sub: segment k is added in stage k, and the carry is registered between stages.
// Latency is SEGS non-held cycles and throughput is one per cycle; hold freezes every register.
module pipe_seg_adder #(
    parameter int WIDTH = 16,
    parameter int SEGS  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] n1,
    input  logic [WIDTH-1:0] n2,
    input  logic             sub,
    input  logic             sgn,
    input  logic             hold,
    output logic             out_valid,
    output logic [WIDTH:0]   sum,
    output logic             ovf
);

    localparam int SEG_W = (SEGS >= 1) ? WIDTH / SEGS : WIDTH;
    localparam int LAST  = (SEGS >= 1) ? SEGS - 1 : 0;

    if (SEGS < 1 || (WIDTH % SEGS) != 0) begin : g_bad_cfg
        $error("pipe_seg_adder: WIDTH must be a positive multiple of SEGS");
    end

    // Stage registers: row k is the state leaving stage k. Columns are segments;
    // columns above k still hold raw operands, and columns up to k hold finished sum segments.
    logic             v_q   [SEGS];
    logic             c_q   [SEGS];
    logic             sub_q [SEGS];
    logic             sgn_q [SEGS];
    logic [SEG_W-1:0] a_q   [SEGS][SEGS];
    logic [SEG_W-1:0] b_q   [SEGS][SEGS];
    logic [SEG_W-1:0] s_q   [SEGS][SEGS];
    logic             msb_q;
    logic             ovf_q;

    // Stage inputs: row 0 comes from the ports, and row k comes from register row k-1.
    logic             in_v   [SEGS];
    logic             in_c   [SEGS];
    logic             in_sub [SEGS];
    logic             in_sgn [SEGS];
    logic [SEG_W-1:0] in_a   [SEGS][SEGS];
    logic [SEG_W-1:0] in_b   [SEGS][SEGS];
    logic [SEG_W-1:0] in_s   [SEGS][SEGS];

    logic [SEG_W-1:0] seg_s  [SEGS];
    logic             seg_co [SEGS];
    logic             fin_msb;
    logic             fin_ovf;

    always_comb begin
        in_v[0]   = in_valid;
        in_c[0]   = sub;
        in_sub[0] = sub;
        in_sgn[0] = sgn;
        for (int j = 0; j < SEGS; j++) begin
            in_a[0][j] = n1[j*SEG_W +: SEG_W];
            in_b[0][j] = n2[j*SEG_W +: SEG_W] ^ {SEG_W{sub}};
            in_s[0][j] = '0;
        end
        for (int k = 1; k < SEGS; k++) begin
            in_v[k]   = v_q[k-1];
            in_c[k]   = c_q[k-1];
            in_sub[k] = sub_q[k-1];
            in_sgn[k] = sgn_q[k-1];
            for (int j = 0; j < SEGS; j++) begin
                in_a[k][j] = a_q[k-1][j];
                in_b[k][j] = b_q[k-1][j];
                in_s[k][j] = s_q[k-1][j];
            end
        end
    end

    for (genvar k = 0; k < SEGS; k++) begin : g_stage
        adder_seg #(.W(SEG_W)) u_seg (
            .a    (in_a[k][k]),
            .b    (in_b[k][k]),
            .cin  (in_c[k]),
            .s    (seg_s[k]),
            .cout (seg_co[k])
        );
    end

    // The top bit is a sign extension of the exact result, the carry, or the borrow, depending on the mode.
    always_comb begin
        fin_msb = 1'b0;
        if (in_sgn[LAST])
            fin_msb = in_a[LAST][LAST][SEG_W-1] ^ in_b[LAST][LAST][SEG_W-1] ^ seg_co[LAST];
        else if (in_sub[LAST])
            fin_msb = ~seg_co[LAST];
        else
            fin_msb = seg_co[LAST];
        fin_ovf = in_sgn[LAST] ? (fin_msb ^ seg_s[LAST][SEG_W-1]) : fin_msb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            msb_q <= 1'b0;
            ovf_q <= 1'b0;
            for (int k = 0; k < SEGS; k++) begin
                v_q[k]   <= 1'b0;
                c_q[k]   <= 1'b0;
                sub_q[k] <= 1'b0;
                sgn_q[k] <= 1'b0;
                for (int j = 0; j < SEGS; j++) begin
                    a_q[k][j] <= '0;
                    b_q[k][j] <= '0;
                    s_q[k][j] <= '0;
                end
            end
        end else if (!hold) begin
            msb_q <= fin_msb;
            ovf_q <= fin_ovf;
            for (int k = 0; k < SEGS; k++) begin
                v_q[k]   <= in_v[k];
                c_q[k]   <= seg_co[k];
                sub_q[k] <= in_sub[k];
                sgn_q[k] <= in_sgn[k];
                for (int j = 0; j < SEGS; j++) begin
                    a_q[k][j] <= in_a[k][j];
                    b_q[k][j] <= in_b[k][j];
                    s_q[k][j] <= (j == k) ? seg_s[k] : in_s[k][j];
                end
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign ovf       = ovf_q;

    always_comb begin
        sum        = '0;
        sum[WIDTH] = msb_q;
        for (int j = 0; j < SEGS; j++)
            sum[j*SEG_W +: SEG_W] = s_q[LAST][j];
    end

endmodule
